sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM (1-cycle read latency) between the fetch requester (IF stage) and the load/store requester (MEM stage).
- Each requester uses a req/addr_ok/data_ok handshake.
- The arbiter grants at most one request per cycle and routes each response back to its owner.
- It sits between the pipeline stages and the unified memory, replacing separate inst/data SRAM ports.

Parameters:
- ADDR_W, 32, address width of all ports.
- STARVE_MAX, 4, consecutive cycles fetch may lose arbitration before it is forced to win; legal 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_req  in  1  fetch request valid
- inst_addr  in  ADDR_W  fetch byte address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch response valid
- inst_rdata  out  32  fetch read data
- data_req  in  1  load/store request valid
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  store byte enables
- data_addr  in  ADDR_W  load/store byte address
- data_wdata  in  32  store data
- data_addr_ok  out  1  load/store request accepted this cycle
- data_data_ok  out  1  load/store response valid (loads and stores)
- data_rdata  out  32  load read data
- mem_en  out  1  SRAM access enable
- mem_wen  out  4  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. All state clears on the reset edge.
- Reset values: resp_valid=0, resp_owner=INST, starve_cnt=0. All *_ok outputs are 0 and mem_en=0 while reset is high.
- Grant is combinational each cycle:
  - Only one requester active: it wins.
  - Both active: data wins, unless starve_cnt==STARVE_MAX, in which case inst wins.
  - Winner's addr_ok=1 the same cycle. Loser's addr_ok=0, and it must hold its request.
- Memory drive:
  - mem_en = any grant.
  - mem_addr/mem_wdata come from the winner.
  - mem_wen = data_wstrb when data wins with data_wr=1; otherwise 4'h0. Fetch never writes.
  - No grant: mem_wen=0; mem_addr/mem_wdata are don't-care.
- Response pipeline:
  - On the grant edge: resp_valid<=mem_en, resp_owner<=winner.
  - Next cycle: owner's data_ok=1 and its rdata=mem_rdata. The non-owner's data_ok=0.
  - Latency is exactly 1 cycle from addr_ok to data_ok; no backpressure on responses.
  - data_ok is asserted for stores too; data_rdata is don't-care for stores.
- Throughput: one grant per cycle, back-to-back, with no bubble between owners.
- starve_cnt (4 bits), updated on every clock edge:
  - inst_req=1 and data wins: increment, saturating at STARVE_MAX.
  - inst wins or inst_req=0: clear to 0.
- Simultaneous events:
  - A grant and a response of different owners in the same cycle are independent.
  - Each requester sees at most one data_ok per cycle.
- Reset mid-operation: an in-flight response is dropped (resp_valid cleared), so no data_ok appears after reset deasserts.
- Addresses are passed through unmodified; alignment checks belong to the requesters.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: on conflicts, a 1-bit last_winner register selects the opposite requester. last_winner resets to DATA, so fetch wins the first conflict. last_winner updates only on conflict cycles. starve_cnt is not built.
- Undefined: fixed data priority plus the STARVE_MAX starvation counter, as above.

Decomposition:
- Shared header mycpu.h gains:
  - owner encoding constants OWNER_INST=1'b0, OWNER_DATA=1'b1;
  - SRAM_ARB_STARVE_W=4.
- One sub-module, sram_arb_grant: the combinational winner select plus the starve/round-robin state. Its ports are inst_req, data_req, clk, reset and gnt_inst/gnt_data outputs.
- The top level handles the memory muxing and the response register.

Test Plan:
- Reset held 3 cycles with both reqs=1 -> mem_en=0, all *_ok=0. First cycle after release: data_addr_ok=1.
- Fetch-only read: inst_req at 0x1C000000, SRAM returns 0x02800413 -> inst_addr_ok in cycle T, inst_data_ok with inst_rdata=0x02800413 in T+1, data_data_ok=0.
- Store then load: store 0xDEADBEEF to 0x100 with wstrb=4'b0011, then load 0x100 -> mem_wen=0011 in the store cycle; load returns 0x????BEEF with the upper half unchanged; data_data_ok=1 in both response cycles.
- Continuous conflict, STARVE_MAX=4, macro undefined -> data wins 4 cycles, inst wins the 5th, pattern D,D,D,D,I repeats.
- Same conflict with SRAM_ARB_RR_EN defined -> grants alternate I,D,I,D starting with inst.
- Reset asserted the cycle after an inst grant -> no inst_data_ok is produced afterwards. First post-reset grant behaves as after a clean reset.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the unified-SRAM port arbiter.
// Owner encoding tags each response with the requester it belongs to.
package sram_port_arbiter_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam int SRAM_ARB_STARVE_W = 4;

endpackage

// File: rtl/sram_arb_grant.sv
// Winner select for the two SRAM requesters.
// Default build: data has priority, and a saturating starvation counter
// forces a fetch win after STARVE_MAX consecutive lost conflicts.
// With SRAM_ARB_RR_EN defined: conflicts alternate through a last_winner
// bit, and no starvation counter is built.
// The outputs are raw grants. The top level masks them during reset.
module sram_arb_grant
  import sram_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inst_req,
  input  logic data_req,
  output logic gnt_inst,
  output logic gnt_data
);

  logic conflict;
  assign conflict = inst_req & data_req;

`ifdef SRAM_ARB_RR_EN

  owner_e last_winner;

  // Conflict winner is the opposite of the previous conflict winner.
  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    if (conflict) begin
      gnt_inst = (last_winner == OWNER_DATA);
      gnt_data = (last_winner == OWNER_INST);
    end else begin
      gnt_inst = inst_req;
      gnt_data = data_req;
    end
  end

  // last_winner changes only on conflict cycles. It resets to DATA, so fetch takes the first conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner <= OWNER_DATA;
    end else if (conflict) begin
      last_winner <= gnt_inst ? OWNER_INST : OWNER_DATA;
    end
  end

`else

  localparam logic [SRAM_ARB_STARVE_W-1:0] STARVE_LIM = STARVE_MAX[SRAM_ARB_STARVE_W-1:0];

  logic [SRAM_ARB_STARVE_W-1:0] starve_cnt;
  logic                         force_inst;

  assign force_inst = (starve_cnt == STARVE_LIM);

  // Data wins conflicts unless fetch has lost STARVE_MAX times in a row.
  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    if (conflict) begin
      gnt_inst = force_inst;
      gnt_data = ~force_inst;
    end else begin
      gnt_inst = inst_req;
      gnt_data = data_req;
    end
  end

  // Count consecutive fetch losses, saturating at the limit. Clear on a fetch win or when fetch is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (inst_req && gnt_data) begin
      starve_cnt <= force_inst ? starve_cnt : starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM (1-cycle read latency) between
// the fetch (inst_*) and load/store (data_*) requesters.
// Optional feature: define SRAM_ARB_RR_EN for round-robin conflict
// resolution instead of data priority with a starvation limit.
//
// Handshake, per requester:
//   - req is valid. A requester that sees addr_ok=0 must hold req and its
//     address and data stable.
//   - addr_ok=1 in a cycle means the request was accepted at that clock edge.
//   - data_ok=1 comes exactly one cycle after addr_ok, for loads and stores.
//     There is no backpressure on responses.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic   gnt_inst;
  logic   gnt_data;
  logic   resp_valid;
  owner_e resp_owner;

  sram_arb_grant #(
    .STARVE_MAX(STARVE_MAX)
  ) u_grant (
    .clk      (clk),
    .reset    (reset),
    .inst_req (inst_req),
    .data_req (data_req),
    .gnt_inst (gnt_inst),
    .gnt_data (gnt_data)
  );

  // Grants are blocked while reset is high, so nothing is accepted and the SRAM stays idle.
  always_comb begin
    inst_addr_ok = gnt_inst & ~reset;
    data_addr_ok = gnt_data & ~reset;
  end

  // Drive the SRAM from the winner. Fetch never writes, so wdata can always come from the data port.
  always_comb begin
    mem_en    = inst_addr_ok | data_addr_ok;
    mem_addr  = data_addr_ok ? data_addr : inst_addr;
    mem_wdata = data_wdata;
    mem_wen   = (data_addr_ok && data_wr) ? data_wstrb : 4'h0;
  end

  // Record who owns the SRAM output in the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_owner <= OWNER_INST;
    end else begin
      resp_valid <= mem_en;
      resp_owner <= data_addr_ok ? OWNER_DATA : OWNER_INST;
    end
  end

  // Route the SRAM read data to its owner. Only one data_ok can be active per cycle.
  always_comb begin
    inst_data_ok = resp_valid & ~reset & (resp_owner == OWNER_INST);
    data_data_ok = resp_valid & ~reset & (resp_owner == OWNER_DATA);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter, with a behavioural SRAM model.
// It covers reset, fetch-only reads, a store followed by a load, the
// conflict grant pattern, and reset arriving mid-flight.
// The conflict pattern follows SRAM_ARB_RR_EN if that macro is defined.
module tb_sram_port_arbiter;

  localparam int ADDR_W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              inst_req = 1'b0;
  logic [ADDR_W-1:0] inst_addr = '0;
  logic              inst_addr_ok, inst_data_ok;
  logic [31:0]       inst_rdata;
  logic              data_req = 1'b0;
  logic              data_wr = 1'b0;
  logic [3:0]        data_wstrb = 4'h0;
  logic [ADDR_W-1:0] data_addr = '0;
  logic [31:0]       data_wdata = '0;
  logic              data_addr_ok, data_data_ok;
  logic [31:0]       data_rdata;
  logic              mem_en;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // SRAM model: word array, byte writes, read-first, 1-cycle read latency.
  // The words used by the tests are preloaded during reset.
  logic [31:0] sram [0:255];
  always @(posedge clk) begin
    if (reset) begin
      sram[0]  <= 32'h0280_0413;
      sram[64] <= 32'h1234_5678;
    end else if (mem_en) begin
      mem_rdata <= sram[mem_addr[9:2]];
      for (int b = 0; b < 4; b++) begin
        if (mem_wen[b]) sram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    inst_req = 1'b0;
    data_req = 1'b0;
    data_wr  = 1'b0;
  endtask

  logic exp_inst_win;
  logic first_inst;

  initial begin
    // Reset held for 3 cycles while both requesters are active.
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0000;
    data_req  = 1'b1;
    data_addr = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mem_en", {31'd0, mem_en}, 32'd0);
      check("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      check("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
`ifdef SRAM_ARB_RR_EN
    first_inst = 1'b1;
`else
    first_inst = 1'b0;
`endif
    check("post_rst_inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, first_inst});
    check("post_rst_data_addr_ok", {31'd0, data_addr_ok}, {31'd0, ~first_inst});

    // Idle cycle to drain the response from the first grant.
    tick();
    drive_idle();
    @(negedge clk);
    check("idle_mem_en", {31'd0, mem_en}, 32'd0);

    // Fetch-only read.
    tick();
    inst_req  = 1'b1;
    inst_addr = 32'h1C00_0000;
    @(negedge clk);
    check("fetch_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    check("fetch_mem_addr", mem_addr, 32'h1C00_0000);
    check("fetch_mem_wen", {28'd0, mem_wen}, 32'd0);
    tick();
    drive_idle();
    @(negedge clk);
    check("fetch_data_ok", {31'd0, inst_data_ok}, 32'd1);
    check("fetch_rdata", inst_rdata, 32'h0280_0413);
    check("fetch_no_data_ok", {31'd0, data_data_ok}, 32'd0);

    // Store the low half of 0xDEADBEEF to 0x100, then load it back.
    tick();
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'b0011;
    data_addr  = 32'h0000_0100;
    data_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("store_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    check("store_mem_wen", {28'd0, mem_wen}, 32'h3);
    check("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    data_wr = 1'b0;
    @(negedge clk);
    check("store_data_ok", {31'd0, data_data_ok}, 32'd1);
    check("load_mem_wen", {28'd0, mem_wen}, 32'd0);
    check("load_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    tick();
    drive_idle();
    @(negedge clk);
    check("load_data_ok", {31'd0, data_data_ok}, 32'd1);
    check("load_rdata", data_rdata, 32'h1234_BEEF);
    check("load_no_inst_ok", {31'd0, inst_data_ok}, 32'd0);

    // A fetch grant immediately followed by reset: its response must be dropped.
    tick();
    inst_req = 1'b1;
    @(negedge clk);
    check("pre_rst_fetch_ok", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    reset    = 1'b1;
    data_req = 1'b1;
    @(negedge clk);
    check("in_rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    check("in_rst_mem_en", {31'd0, mem_en}, 32'd0);
    tick();
    reset = 1'b0;

    // Continuous conflict, starting from a clean post-reset state.
    // Data priority gives D,D,D,D,I,... and round-robin gives I,D,I,D,...
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
`ifdef SRAM_ARB_RR_EN
      exp_inst_win = ((c % 2) == 0);
`else
      exp_inst_win = ((c % 5) == 4);
`endif
      if (c == 0) begin
        check("post_rst_no_inst_ok", {31'd0, inst_data_ok}, 32'd0);
        check("post_rst_no_data_ok", {31'd0, data_data_ok}, 32'd0);
      end else if (exp_q.size() > 0) begin
        logic [0:0] own;
        own = exp_q.pop_front();
        check($sformatf("conf_resp_inst_%0d", c), {31'd0, inst_data_ok}, {31'd0, ~own[0]});
        check($sformatf("conf_resp_data_%0d", c), {31'd0, data_data_ok}, {31'd0, own[0]});
      end
      check($sformatf("conf_gnt_inst_%0d", c), {31'd0, inst_addr_ok}, {31'd0, exp_inst_win});
      check($sformatf("conf_gnt_data_%0d", c), {31'd0, data_addr_ok}, {31'd0, ~exp_inst_win});
      exp_q.push_back(~exp_inst_win);
      tick();
    end

    // Drain the last conflict response.
    drive_idle();
    @(negedge clk);
    if (exp_q.size() > 0) begin
      logic [0:0] own;
      own = exp_q.pop_front();
      check("drain_resp_data", {31'd0, data_data_ok}, {31'd0, own[0]});
    end
    check("drain_mem_en", {31'd0, mem_en}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
